// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    SHL   = 4'd5,
    SHR   = 4'd6,
    SRA   = 4'd7,
    MUL   = 4'd8,
    PASSA = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Bit positions inside flags_o = {ERR,V,N,Z,C}
  localparam int FLG_C     = 0;
  localparam int FLG_Z     = 1;
  localparam int FLG_N     = 2;
  localparam int FLG_V     = 3;
  localparam int FLG_ERR   = 4;
  localparam int NUM_FLAGS = 5;

  // Ops that may need the iterative datapath (shifts only when amount > 0)
  function automatic logic is_iterative(logic [3:0] op);
    return (op == SHL) || (op == SHR) || (op == SRA) || (op == MUL);
  endfunction

endpackage

// File: rtl/cla_nbits.sv
// Parametrised combinational carry-lookahead adder.
// Every carry is a flat sum-of-products of generate/propagate terms, so no
// carry depends on another carry.
module cla_nbits #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign gen[gi]   = a_i[gi] & b_i[gi];
    assign prop[gi]  = a_i[gi] ^ b_i[gi];
    assign sum_o[gi] = prop[gi] ^ carry[gi];
  end

  // Expand carry[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c_i
  always_comb begin
    logic prod;
    carry    = '0;
    carry[0] = c_i;
    prod     = 1'b1;
    for (int i = 1; i <= WIDTH; i++) begin
      prod     = 1'b1;
      carry[i] = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        carry[i] = carry[i] | (prod & gen[j]);
        prod     = prod & prop[j];
      end
      carry[i] = carry[i] | (prod & c_i);
    end
  end

  assign c_o = carry[WIDTH];

endmodule

// File: rtl/alu_seq_nbits.sv
// Multi-cycle N-bit ALU: single-cycle ops finish on the accept edge, shifts
// move one bit per cycle and MUL runs a WIDTH-step shift-add. The result and
// flags are registered and held until the consumer takes them.
module alu_seq_nbits
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y_o,
  output logic [NUM_FLAGS-1:0] flags_o
);

  // Counter must be able to hold WIDTH for the MUL iteration count
  localparam int CW = $clog2(WIDTH + 1);

  alu_state_e           state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  logic [SHW-1:0]       amt_i;
  logic                 start_iter;
  logic                 last_iter;

  logic [WIDTH-1:0]     cla_a, cla_b, cla_sum;
  logic                 cla_cin, cla_cout;

  assign amt_i      = b_i[SHW-1:0];
  assign start_iter = is_iterative(op_i) && ((op_i == MUL) || (amt_i != '0));
  assign last_iter  = (cnt_q == CW'(1));

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic [WIDTH-1:0] y,
    input logic             c,
    input logic             v,
    input logic             err
  );
    logic [NUM_FLAGS-1:0] f;
    f          = '0;
    f[FLG_C]   = c;
    f[FLG_Z]   = (y == '0);
    f[FLG_N]   = y[WIDTH-1];
    f[FLG_V]   = v;
    f[FLG_ERR] = err;
    return f;
  endfunction

  cla_nbits #(.WIDTH(WIDTH)) u_cla (
    .a_i   (cla_a),
    .b_i   (cla_b),
    .c_i   (cla_cin),
    .sum_o (cla_sum),
    .c_o   (cla_cout)
  );

  // Adder operands: live inputs for ADD/SUB at accept, partial product during EXEC
  always_comb begin
    cla_a   = a_i;
    cla_b   = (op_i == SUB) ? ~b_i : b_i;
    cla_cin = (op_i == SUB);
    if (state_q == EXEC) begin
      cla_a   = acc_q[2*WIDTH-1:WIDTH];
      cla_b   = work_q;
      cla_cin = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = start_iter ? EXEC : DONE;
      EXEC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in EXEC, capture result on DONE entry
  always_comb begin
    logic [WIDTH-1:0] res;
    logic             c_bit, v_bit, err_bit, load;
    op_d    = op_q;
    work_d  = work_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    flags_d = flags_q;
    res     = '0;
    c_bit   = 1'b0;
    v_bit   = 1'b0;
    err_bit = 1'b0;
    load    = 1'b0;

    if ((state_q == IDLE) && in_valid) begin
      op_d = op_i;
      if (start_iter) begin
        work_d = a_i;
        acc_d  = {{WIDTH{1'b0}}, b_i};
        cnt_d  = (op_i == MUL) ? CW'(WIDTH) : CW'(amt_i);
      end else begin
        load = 1'b1;
        case (op_i)
          ADD: begin
            res   = cla_sum;
            c_bit = cla_cout;
            v_bit = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
          end
          SUB: begin
            res   = cla_sum;
            c_bit = cla_cout;
            v_bit = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ res[WIDTH-1]);
          end
          AND:                   res = a_i & b_i;
          OR:                    res = a_i | b_i;
          XOR:                   res = a_i ^ b_i;
          SHL, SHR, SRA, PASSA:  res = a_i;  // zero-amount shifts pass A through
          default: begin
            res     = '0;
            err_bit = 1'b1;
          end
        endcase
      end
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q - CW'(1);
      case (op_q)
        SHL: begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          c_bit  = work_q[WIDTH-1];
        end
        SHR: begin
          work_d = {1'b0, work_q[WIDTH-1:1]};
          c_bit  = work_q[0];
        end
        SRA: begin
          work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
          c_bit  = work_q[0];
        end
        MUL: begin
          acc_d = acc_q[0] ? {cla_cout, cla_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};
        end
        default: ;
      endcase
      if (op_q == MUL) begin
        res   = acc_d[WIDTH-1:0];
        v_bit = (acc_d[2*WIDTH-1:WIDTH] != '0);
        c_bit = 1'b0;
      end else begin
        res = work_d;
      end
      load = last_iter;
    end

    if (load) begin
      y_d     = res;
      flags_d = pack_flags(res, c_bit, v_bit, err_bit);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  // Handshake and result outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    y_o       = y_q;
    flags_o   = flags_q;
  end

endmodule

// File: tb/tb_alu_seq_nbits.sv
// Self-checking bench for alu_seq_nbits (WIDTH=8): directed cases followed by
// random ops, compared against an arithmetic reference model.
module tb_alu_seq_nbits;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_o;
  logic [4:0]   flags_o;

  int tests = 0;
  int fails = 0;

  alu_seq_nbits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_o       (y_o),
    .flags_o   (flags_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sext(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - 256 : int'(v);
  endfunction

  // Reference model: result, {ERR,V,N,Z,C} and accept-to-valid latency
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] y, output logic [4:0] f, output int lat);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             amt, sr;
    logic           c, v, err;
    c = 0; v = 0; err = 0; lat = 1;
    amt = int'(b[2:0]);
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b}; y = s[W-1:0]; c = s[W];
        sr = sext(a) + sext(b); v = (sr > 127) || (sr < -128);
      end
      4'd1: begin
        y = a - b; c = (a >= b);
        sr = sext(a) - sext(b); v = (sr > 127) || (sr < -128);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: begin y = a << amt; c = (amt != 0) ? a[W-amt] : 1'b0; lat = 1 + amt; end
      4'd6: begin y = a >> amt; c = (amt != 0) ? a[amt-1] : 1'b0; lat = 1 + amt; end
      4'd7: begin y = W'($signed(a) >>> amt); c = (amt != 0) ? a[amt-1] : 1'b0; lat = 1 + amt; end
      4'd8: begin p = a * b; y = p[W-1:0]; v = (p[2*W-1:W] != 0); lat = 1 + W; end
      4'd9: y = a;
      default: begin y = '0; err = 1; end
    endcase
    f = {err, v, y[W-1], (y == 0), c};
  endtask

  // Present an op, wait for its result; lat counts negedges from accept to out_valid
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1; op_i = op; a_i = a; b_i = b;
    @(posedge clk);
    #1;
    in_valid = 0; op_i = 4'($urandom); a_i = W'($urandom); b_i = W'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  // Take the result, then confirm the block is idle and ready again
  task automatic consume(input string tag);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    @(negedge clk);
    check({tag, "_ovalid_low"}, 32'(out_valid), 32'd0);
    check({tag, "_iready_high"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_check(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string tag);
    logic [W-1:0] ey;
    logic [4:0]   ef;
    int           el, lat;
    model(op, a, b, ey, ef, el);
    issue(op, a, b, lat);
    $display("[TB] %s op=%0d a=0x%02h b=0x%02h -> y=0x%02h flags=%05b lat=%0d (exp y=0x%02h flags=%05b lat=%0d)",
             tag, op, a, b, y_o, flags_o, lat, ey, ef, el);
    check({tag, "_y"}, 32'(y_o), 32'(ey));
    check({tag, "_flags"}, 32'(flags_o), 32'(ef));
    check({tag, "_lat"}, 32'(lat), 32'(el));
    consume(tag);
  endtask

  initial begin
    logic [W-1:0] hy, ey;
    logic [4:0]   hf, ef;
    int           el, lat;

    rst = 1; in_valid = 0; out_ready = 0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_y", 32'(y_o), 32'd0);
    check("reset_flags", 32'(flags_o), 32'd0);
    rst = 0;

    // Directed cases
    run_check(4'd0, 8'h7F, 8'h01, "add_ovf");
    check("add_ovf_literal_y", 32'(y_o), 32'h80);
    check("add_ovf_literal_flags", 32'(flags_o), 32'b01100);
    run_check(4'd1, 8'h05, 8'h05, "sub_zero");
    run_check(4'd1, 8'h00, 8'h01, "sub_borrow");
    run_check(4'd7, 8'h90, 8'h03, "sra3");
    run_check(4'd5, 8'h81, 8'h00, "shl0");
    run_check(4'd8, 8'h10, 8'h11, "mul_ovf");
    run_check(4'd8, 8'h0F, 8'h0F, "mul_e1");
    run_check(4'd6, 8'h81, 8'h07, "shr7");
    run_check(4'd5, 8'h81, 8'h07, "shl7");
    run_check(4'd2, 8'hF0, 8'h3C, "and");
    run_check(4'd3, 8'hF0, 8'h0C, "or");
    run_check(4'd4, 8'hFF, 8'hFF, "xor_zero");
    run_check(4'd9, 8'hA5, 8'h00, "passa");
    run_check(4'd15, 8'hFF, 8'hFF, "illegal15");

    // Hold: result must stay put while out_ready is low; new in_valid ignored
    model(4'd8, 8'h23, 8'h45, ey, ef, el);
    issue(4'd8, 8'h23, 8'h45, lat);
    check("hold_lat", 32'(lat), 32'(el));
    hy = y_o; hf = flags_o;
    check("hold_y_initial", 32'(hy), 32'(ey));
    check("hold_flags_initial", 32'(hf), 32'(ef));
    in_valid = 1; op_i = 4'd0; a_i = 8'h11; b_i = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_y", 32'(y_o), 32'(ey));
      check("hold_flags", 32'(flags_o), 32'(ef));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    $display("[TB] hold mul 0x23*0x45 y=0x%02h flags=%05b held 5 cycles", y_o, flags_o);
    in_valid = 0;
    consume("hold");
    repeat (3) @(negedge clk);
    check("hold_no_extra_result", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1; op_i = 4'd8; a_i = 8'hFF; b_i = 8'hFF;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    check("midmul_busy", 32'(in_ready), 32'd0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    $display("[TB] reset mid-MUL: in_ready=%0b out_valid=%0b y=0x%02h flags=%05b",
             in_ready, out_valid, y_o, flags_o);
    check("midmul_rst_out_valid", 32'(out_valid), 32'd0);
    check("midmul_rst_in_ready", 32'(in_ready), 32'd1);
    check("midmul_rst_y", 32'(y_o), 32'd0);
    check("midmul_rst_flags", 32'(flags_o), 32'd0);
    repeat (10) @(negedge clk);
    check("midmul_result_lost", 32'(out_valid), 32'd0);
    run_check(4'd12, 8'h5A, 8'hA5, "illegal12");
    check("illegal12_literal_flags", 32'(flags_o), 32'b10010);

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      run_check(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
